// File: rtl/sdft_inverse_pkg.sv
// Shared types and width helpers for the sliding-DFT inverse (reconstruction) stage.
package sdft_pkg;

    typedef enum logic {FULL, HALF} spectrum_e;
    typedef enum logic {IDLE, ACCUM} state_e;

    function automatic int last_bin(input int n, input spectrum_e mode);
        return (mode == FULL) ? n - 1 : n / 2 - 1;
    endfunction

    // Product carries one guard bit for the half-spectrum doubling.
    function automatic int prod_width(input int idw);
        return idw + 2;
    endfunction

    function automatic int acc_width(input int idw, input int aw);
        return idw + aw + 2;
    endfunction

    // One extra bit so the rounding constant can be added without overflow.
    function automatic int sum_width(input int idw, input int aw);
        return idw + aw + 3;
    endfunction

endpackage

// File: rtl/sdft_inverse_mac_re.sv
// Registered real part of bin * twiddle, scaled back from Q1.(CW-1), with optional x2.
module sdft_mac_re #(
    parameter int IDW = 32,
    parameter int CW  = 16
) (
    input  logic                  clk_i,
    input  logic signed [IDW-1:0] re_i,
    input  logic signed [IDW-1:0] im_i,
    input  logic signed [CW-1:0]  w_re_i,
    input  logic signed [CW-1:0]  w_im_i,
    input  logic                  dbl_i,
    output logic signed [IDW+1:0] p_o
);

    localparam int MW = IDW + CW + 1;

    logic signed [MW-1:0]  mul_re;
    logic signed [MW-1:0]  mul_im;
    logic signed [MW-1:0]  diff;
    logic signed [IDW:0]   p_trunc;
    logic signed [IDW+1:0] p_d;

    always_comb begin
        mul_re  = MW'(re_i) * MW'(w_re_i);
        mul_im  = MW'(im_i) * MW'(w_im_i);
        diff    = mul_re - mul_im;
        p_trunc = (IDW+1)'(diff >>> (CW - 1));
        p_d     = dbl_i ? {p_trunc, 1'b0} : {p_trunc[IDW], p_trunc};
    end

    // ---- stage p1: product register ----
    always_ff @(posedge clk_i) begin
        p_o <= p_d;
    end

endmodule

// File: rtl/sdft_inverse.sv
// Inverse sliding-DFT stage: per-bin twiddle MAC over a framed block, /N with round-half-up, saturate.
module sdft_inverse
    import sdft_pkg::*;
#(
    parameter int    N        = 4096,
    parameter int    DW       = 16,
    parameter int    CW       = 16,
    parameter int    IDW      = 32,
    parameter int    IMAG_EN  = 1,
    parameter int    IW       = IMAG_EN ? 2 * IDW : IDW,
    parameter string SPECTRUM = "full",
    parameter int    AW       = (SPECTRUM == "full") ? $clog2(N) : $clog2(N) - 1
) (
    input  logic                 clk_i,
    input  logic                 srst_ni,
    input  logic [IW-1:0]        data_i,
    input  logic                 valid_i,
    input  logic                 sob_i,
    input  logic                 eob_i,
    output logic [AW-1:0]        twiddle_idx_o,
    input  logic [2*CW-1:0]      twiddle_i,
    output logic signed [DW-1:0] data_o,
    output logic                 valid_o,
    output logic                 sat_alarm_o,
    output logic                 frame_err_o
);

    localparam spectrum_e MODE  = (SPECTRUM == "full") ? FULL : HALF;
    localparam int        LOGN  = $clog2(N);
    localparam int        PW    = prod_width(IDW);
    localparam int        ACC_W = acc_width(IDW, AW);
    localparam int        SUM_W = sum_width(IDW, AW);
    localparam logic [AW-1:0]           LAST_IDX = AW'(last_bin(N, MODE));
    localparam logic signed [SUM_W-1:0] RND      = SUM_W'(1) << (LOGN - 1);
    localparam logic signed [SUM_W-1:0] Y_MAX    = {{(SUM_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] Y_MIN    = {{(SUM_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic signed [SUM_W-1:0] round_half_up(input logic signed [SUM_W-1:0] x);
        return (x + RND) >>> LOGN;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [DW:0] sat_sdft(input logic signed [SUM_W-1:0] y);
        if (y > Y_MAX) return {1'b1, Y_MAX[DW-1:0]};
        if (y < Y_MIN) return {1'b1, Y_MIN[DW-1:0]};
        return {1'b0, y[DW-1:0]};
    endfunction

    logic signed [IDW-1:0] in_re;
    logic signed [IDW-1:0] in_im;

    generate
        if (IMAG_EN != 0) begin : g_cplx
            assign in_re = data_i[IDW-1:0];
            assign in_im = data_i[2*IDW-1:IDW];
        end else begin : g_real
            assign in_re = data_i[IDW-1:0];
            assign in_im = '0;
        end
    endgenerate

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic [AW-1:0] idx;
    logic          start, cont, overrun, accept, good_eob, err;

    // cnt_q holds the index of the last accepted beat of the open block.
    always_comb begin
        start    = valid_i && sob_i;
        cont     = valid_i && !sob_i && (state_q == ACCUM);
        overrun  = cont && (cnt_q == LAST_IDX);
        accept   = start || (cont && !overrun);
        idx      = start ? '0 : cnt_q + AW'(1);
        good_eob = accept && eob_i && (idx == LAST_IDX);
        err      = (start && (state_q == ACCUM)) || (accept && eob_i && (idx != LAST_IDX)) || overrun;
    end

    assign twiddle_idx_o = idx;

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= err;
            if (accept) cnt_q <= idx;
            if (overrun || (accept && eob_i)) state_q <= IDLE;
            else if (accept)                  state_q <= ACCUM;
        end
    end

    logic signed [IDW-1:0]   re_p0, im_p0;
    logic                    vld_p0, first_p0, last_p0, dbl_p0;
    logic signed [PW-1:0]    p_p1;
    logic                    vld_p1, first_p1, last_p1;
    logic signed [ACC_W-1:0] acc_q, acc_base, acc_next;
    logic signed [SUM_W-1:0] sum_p2;
    logic                    vld_p2;
    logic [DW:0]             sat_res;

    // ---- stage p0: align beat with the ROM read ----
    always_ff @(posedge clk_i) begin
        re_p0    <= in_re;
        im_p0    <= in_im;
        first_p0 <= start;
        last_p0  <= good_eob;
        dbl_p0   <= (MODE == HALF) && (idx != '0);
    end

    sdft_mac_re #(
        .IDW (IDW),
        .CW  (CW)
    ) u_mac (
        .clk_i  (clk_i),
        .re_i   (re_p0),
        .im_i   (im_p0),
        .w_re_i (twiddle_i[CW-1:0]),
        .w_im_i (twiddle_i[2*CW-1:CW]),
        .dbl_i  (dbl_p0),
        .p_o    (p_p1)
    );

    // ---- stage p1: flags follow the product register ----
    always_ff @(posedge clk_i) begin
        first_p1 <= first_p0;
        last_p1  <= last_p0;
    end

    // The first-beat flag bypasses acc_q, so a new block never disturbs the final sum in flight.
    always_comb begin
        acc_base = first_p1 ? '0 : acc_q;
        acc_next = acc_base + ACC_W'(p_p1);
        sat_res  = sat_sdft(sum_p2);
    end

    // ---- stage p2: block sum, divide by N ----
    always_ff @(posedge clk_i) begin
        if (vld_p1 && last_p1) sum_p2 <= round_half_up(SUM_W'(acc_base) + SUM_W'(p_p1));
    end

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            vld_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            acc_q       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            sat_alarm_o <= 1'b0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1 && last_p1;
            if (vld_p1) acc_q <= acc_next;
            // ---- stage p3: saturated output ----
            valid_o     <= vld_p2;
            sat_alarm_o <= vld_p2 && sat_res[DW];
            if (vld_p2) data_o <= sat_res[DW-1:0];
        end
    end

endmodule
